// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//
// One-hot select decoder with an optional automatic sweep mode.
//
// In DIRECT mode a select value is accepted through a valid/ready handshake.
// On the accepting edge the value is loaded into idx, and y becomes 1<<idx.
// In SWEEP mode idx advances by one position modulo OUT_W. Each position is
// held for dwell+1 cycles. wrap pulses for the one cycle in which idx rolls
// over from OUT_W-1 to 0.
//
// The en input gates the whole block. While en is low, y and wrap are zero
// and all state is frozen.
//
// Build option:
//   SCAN_DECODER_SWEEP_EN  - when defined, the SWEEP state, the dwell counter
//                            and the wrap logic are compiled in. When it is
//                            undefined, mode and dwell are ignored, wrap is
//                            tied to 0 and the FSM stays in DIRECT. The port
//                            list is the same in both builds.
//
// Parameters:
//   SEL_W    select width (1..6)
//   DWELL_W  dwell counter width
//   OUT_W    derived, 2**SEL_W, not overridable
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         enable; when 0, y is forced to 0 and all state freezes
//   mode       0 = direct, 1 = sweep
//   sel_valid  a new select value is offered
//   sel        select value
//   sel_ready  combinational; high when enabled and in DIRECT
//   dwell      number of extra cycles each sweep position is held
//   y          registered one-hot output
//   idx        registered current index
//   wrap       registered one-cycle pulse when the sweep wraps
// -----------------------------------------------------------------------------
module scan_decoder #(
  parameter  int SEL_W   = 3,
  parameter  int DWELL_W = 4,
  localparam int OUT_W   = 2 ** SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               mode,
  input  logic               sel_valid,
  input  logic [SEL_W-1:0]   sel,
  output logic               sel_ready,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap
);

  typedef enum logic {
    DIRECT = 1'b0,
    SWEEP  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [OUT_W-1:0]   y_q, y_d;
  logic               wrap_q, wrap_d;
  logic               armed_q, armed_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic               transfer;

  assign sel_ready = en && (state_q == DIRECT);
  assign transfer  = sel_valid && sel_ready;

  // y is derived from the next idx and the next armed value. A transfer or a
  // sweep step therefore shows up on y in the same edge that updates idx.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    armed_d     = armed_q;
    dwell_cnt_d = dwell_cnt_q;
    wrap_d      = 1'b0;
    y_d         = '0;
    if (en) begin
      if (transfer) begin
        idx_d   = sel;
        armed_d = 1'b1;
      end
`ifdef SCAN_DECODER_SWEEP_EN
      case (state_q)
        DIRECT: begin
          // A transfer in the same cycle has already loaded idx_d, so the
          // sweep starts from the newly selected index.
          if (mode) begin
            state_d     = SWEEP;
            dwell_cnt_d = '0;
            armed_d     = 1'b1;
          end
        end
        SWEEP: begin
          if (!mode) begin
            state_d = DIRECT;
          end else if (dwell_cnt_q >= dwell) begin
            // The >= comparison makes a lowered dwell take effect at once.
            idx_d       = idx_q + SEL_W'(1);
            dwell_cnt_d = '0;
            wrap_d      = &idx_q;
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
        default: state_d = DIRECT;
      endcase
`endif
      if (armed_d) begin
        y_d = OUT_W'(1) << idx_d;
      end
    end
  end

`ifndef SCAN_DECODER_SWEEP_EN
  // The sweep inputs stay on the port list but have no effect in this build.
  logic unused_sweep;
  assign unused_sweep = ^{mode, dwell, dwell_cnt_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= DIRECT;
      idx_q       <= '0;
      y_q         <= '0;
      wrap_q      <= 1'b0;
      armed_q     <= 1'b0;
      dwell_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      y_q         <= y_d;
      wrap_q      <= wrap_d;
      armed_q     <= armed_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//
// Directed testbench for scan_decoder with SEL_W=3 and DWELL_W=4.
//
// A behavioural model tracks what the outputs must be. It works in plain
// integers: the current position, whether a sweep is running, and how many
// cycles the current position has been held. It is compared against the DUT
// on every falling edge.
//
// Hand-computed literal expectations are also checked at the points of
// interest. Some of those expectations depend on SCAN_DECODER_SWEEP_EN.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       sel_valid;
  logic [2:0] sel;
  logic       sel_ready;
  logic [3:0] dwell;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  int checks   = 0;
  int failures = 0;
  bit checkOn  = 0;

`ifdef SCAN_DECODER_SWEEP_EN
  localparam bit SWEEP_ON = 1'b1;
`else
  localparam bit SWEEP_ON = 1'b0;
`endif

  scan_decoder #(.SEL_W(3), .DWELL_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sel_valid (sel_valid),
    .sel       (sel),
    .sel_ready (sel_ready),
    .dwell     (dwell),
    .y         (y),
    .idx       (idx),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state: position, arming, sweep status and the number
  // of cycles the current position has been held.
  int mPos     = 0;
  bit mArmed   = 0;
  bit mSweep   = 0;
  int mHeld    = 0;
  bit mWrap    = 0;
  bit mOutOn   = 0;

  // The model steps once per rising edge, using the inputs that were set up
  // before that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPos   = 0;
      mArmed = 0;
      mSweep = 0;
      mHeld  = 0;
      mWrap  = 0;
      mOutOn = 0;
    end else if (!en) begin
      mOutOn = 0;
      mWrap  = 0;
    end else begin
      mOutOn = 1;
      mWrap  = 0;
      if (!mSweep) begin
        if (sel_valid) begin
          mPos   = int'(sel);
          mArmed = 1;
        end
        if (SWEEP_ON && mode) begin
          mSweep = 1;
          mHeld  = 0;
          mArmed = 1;
        end
      end else if (!mode) begin
        mSweep = 0;
      end else if (mHeld >= int'(dwell)) begin
        mWrap = (mPos == 7);
        mPos  = (mPos + 1) % 8;
        mHeld = 0;
      end else begin
        mHeld = mHeld + 1;
      end
    end
  end

  function automatic logic [7:0] modelY();
    if (mOutOn && mArmed) return 8'(1 << mPos);
    return 8'h00;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("model_y", 32'(y), 32'(modelY()));
      checkOutput("model_idx", 32'(idx), 32'(mPos));
      checkOutput("model_wrap", 32'(wrap), 32'(mWrap));
      checkOutput("model_sel_ready", 32'(sel_ready), 32'(en && !mSweep));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [2:0] s);
    sel       = s;
    sel_valid = 1'b1;
    tick();
    sel_valid = 1'b0;
  endtask

  logic [7:0] sweepSeq [8];
  logic [7:0] holdSeq  [6];

  initial begin
    sweepSeq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    holdSeq  = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h04};

    rst_n = 1'b1; en = 1'b0; mode = 1'b0; sel_valid = 1'b0; sel = '0; dwell = '0;
    #1 rst_n = 1'b0;
    checkOn = 1'b1;
    #2;
    checkOutput("reset_y", 32'(y), 32'h00);
    checkOutput("reset_idx", 32'(idx), 32'h0);
    checkOutput("reset_wrap", 32'(wrap), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    en    = 1'b1;

    // The block is enabled but nothing has been selected yet.
    tick();
    checkOutput("unarmed_y", 32'(y), 32'h00);

    // Direct transfer of 5.
    applyStimulus(3'd5);
    checkOutput("direct5_y", 32'(y), 32'h20);
    checkOutput("direct5_idx", 32'(idx), 32'h5);
    checkOutput("direct5_ready", 32'(sel_ready), 32'h1);

    // Start from idx 0 and sweep with dwell 0.
    applyStimulus(3'd0);
    checkOutput("direct0_y", 32'(y), 32'h01);
    mode  = 1'b1;
    dwell = 4'd0;
    tick();
    checkOutput("sweep_entry_y", 32'(y), 32'h01);
    for (int k = 0; k < 8; k++) begin
      tick();
`ifdef SCAN_DECODER_SWEEP_EN
      checkOutput("sweep_step_y", 32'(y), 32'(sweepSeq[k]));
      checkOutput("sweep_step_wrap", 32'(wrap), 32'(k == 7));
`else
      checkOutput("nosweep_y", 32'(y), 32'h01);
      checkOutput("nosweep_wrap", 32'(wrap), 32'h0);
`endif
    end

    // Each position is held dwell+1 = 3 cycles.
    dwell = 4'd2;
    for (int k = 0; k < 6; k++) begin
      tick();
`ifdef SCAN_DECODER_SWEEP_EN
      checkOutput("dwell2_y", 32'(y), 32'(holdSeq[k]));
`else
      checkOutput("dwell2_nosweep_y", 32'(y), 32'h01);
`endif
    end
    tick();
    // Lowering dwell mid-hold advances on the next edge.
    dwell = 4'd0;
    tick();
`ifdef SCAN_DECODER_SWEEP_EN
    checkOutput("dwell_drop_y", 32'(y), 32'h08);
    checkOutput("dwell_drop_idx", 32'(idx), 32'h3);
`endif

    // Freeze at idx 3, then resume.
    en    = 1'b0;
    dwell = 4'd1;
    #1;
    checkOutput("freeze_ready", 32'(sel_ready), 32'h0);
    tick();
    checkOutput("freeze_y", 32'(y), 32'h00);
    checkOutput("freeze_wrap", 32'(wrap), 32'h0);
    tick();
    en = 1'b1;
    tick();
`ifdef SCAN_DECODER_SWEEP_EN
    checkOutput("resume_y", 32'(y), 32'h08);
    tick();
    checkOutput("resume_next_y", 32'(y), 32'h10);
`else
    checkOutput("resume_nosweep_y", 32'(y), 32'h01);
`endif

    // Asynchronous reset between edges, then a fresh transfer.
    #4 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_y", 32'(y), 32'h00);
    checkOutput("async_rst_idx", 32'(idx), 32'h0);
    checkOutput("async_rst_wrap", 32'(wrap), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    mode  = 1'b0;
    applyStimulus(3'd2);
    checkOutput("post_rst_y", 32'(y), 32'h04);
    checkOutput("post_rst_idx", 32'(idx), 32'h2);

    // A transfer coinciding with mode rising: the sweep starts from 7.
    dwell = 4'd0;
    mode  = 1'b1;
    applyStimulus(3'd7);
    checkOutput("sel7_y", 32'(y), 32'h80);
    checkOutput("sel7_idx", 32'(idx), 32'h7);
    checkOutput("sel7_wrap", 32'(wrap), 32'h0);
`ifdef SCAN_DECODER_SWEEP_EN
    checkOutput("sel7_ready", 32'(sel_ready), 32'h0);
    tick();
    checkOutput("sel7_wrap_y", 32'(y), 32'h01);
    checkOutput("sel7_wrap_pulse", 32'(wrap), 32'h1);
    tick();
    checkOutput("sel7_after_y", 32'(y), 32'h02);
    checkOutput("sel7_after_wrap", 32'(wrap), 32'h0);
`else
    checkOutput("sel7_ready", 32'(sel_ready), 32'h1);
    tick();
    checkOutput("sel7_hold_y", 32'(y), 32'h80);
    checkOutput("sel7_hold_wrap", 32'(wrap), 32'h0);
`endif
    mode = 1'b0;
    tick();

    // A select offered while disabled is not taken.
    en        = 1'b0;
    sel       = 3'd6;
    sel_valid = 1'b1;
    tick();
    checkOutput("disabled_y", 32'(y), 32'h00);
    sel_valid = 1'b0;
    en        = 1'b1;
    tick();
`ifdef SCAN_DECODER_SWEEP_EN
    checkOutput("disabled_keep_idx", 32'(idx), 32'h1);
`else
    checkOutput("disabled_keep_idx", 32'(idx), 32'h7);
`endif
    repeat (2) tick();

    checkOn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
